tinker_fetch_unit: RTL and testbench

Instruction-fetch stage for the tinker pipelined core. It owns the PC and reads 32-bit instructions from the byte-addressed unified memory's combinational instruction port. Fetched {PC, instruction} pairs are queued in a small prefetch FIFO, and the FIFO head is presented to the decode stage (IF/ID register) with a valid/ready handshake. It handles the post-reset startup bubble, PC redirects from EX (jump/brnz/brgt/call/return), and halt detection at fetch.

---
 rtl/tinker_fetch_unit.sv | 97 +++++++++
 tb/tb_tinker_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinker_fetch_unit.sv
// tinker_fetch_unit: owns the PC, fetches from the instruction port into a prefetch FIFO feeding decode.
module tinker_fetch_unit #(
    parameter logic [63:0] INIT_PC        = 64'h2000,
    parameter int          DEPTH          = 4,
    parameter int          STARTUP_CYCLES = 5,
    parameter logic [4:0]  HALT_OPCODE    = 5'h0f
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [63:0]              imem_addr,
    output logic                     imem_en,
    input  logic [31:0]              imem_data,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc,
    input  logic                     id_ready,
    output logic                     if_valid,
    output logic [63:0]              if_pc,
    output logic [31:0]              if_instr,
    output logic                     fetch_halted,
    output logic                     misalign_err,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int CW = $clog2(STARTUP_CYCLES + 2);

    typedef enum logic [1:0] {ST_STARTUP, ST_RUN, ST_HALTED} state_t;

    state_t          r_state, w_state_nx;
    logic [CW-1:0]   r_cnt;
    logic [63:0]     r_pc;
    logic [AW-1:0]   r_wp, r_rp;
    logic [OW-1:0]   r_occ;
    logic            r_halted, r_misal;
    logic [63:0]     r_qpc [DEPTH];
    logic [31:0]     r_qin [DEPTH];
    logic            w_deq, w_redir, w_misal, w_fetch, w_halt;

    assign if_valid     = r_occ != '0;
    assign if_pc        = if_valid ? r_qpc[r_rp] : '0;
    assign if_instr     = if_valid ? r_qin[r_rp] : '0;
    assign occupancy    = r_occ;
    assign imem_addr    = r_pc;
    assign imem_en      = w_fetch;
    assign fetch_halted = r_halted;
    assign misalign_err = r_misal;

    assign w_deq   = if_valid && id_ready;
    assign w_redir = (r_state == ST_RUN) && redirect_valid;
    assign w_misal = w_redir && (redirect_pc[1:0] != 2'b00);
    assign w_fetch = (r_state == ST_RUN) && !redirect_valid && ((r_occ < OW'(DEPTH)) || w_deq);
    assign w_halt  = w_fetch && (imem_data[31:27] == HALT_OPCODE);

    always_comb begin
        w_state_nx = (w_misal || w_halt) ? ST_HALTED :
                     (r_state == ST_STARTUP && r_cnt <= CW'(1)) ? ST_RUN : r_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_STARTUP;
            r_cnt    <= CW'(STARTUP_CYCLES);
            r_pc     <= INIT_PC;
            r_wp     <= '0;
            r_rp     <= '0;
            r_occ    <= '0;
            r_halted <= 1'b0;
            r_misal  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_halted <= r_halted || w_halt || w_misal;
            r_misal  <= r_misal || w_misal;
            if (r_state == ST_STARTUP && r_cnt != '0)
                r_cnt <= r_cnt - CW'(1);
            if (w_redir) begin
                // a misaligned target freezes the PC where it was
                r_pc  <= w_misal ? r_pc : redirect_pc;
                r_wp  <= '0;
                r_rp  <= '0;
                r_occ <= '0;
            end else begin
                r_pc  <= w_fetch ? r_pc + 64'd4 : r_pc;
                r_wp  <= r_wp + AW'(w_fetch);
                r_rp  <= r_rp + AW'(w_deq);
                r_occ <= r_occ + OW'(w_fetch) - OW'(w_deq);
            end
        end
    end

    // when full with a transfer, the write slot equals the head being consumed
    always_ff @(posedge clk) begin
        if (w_fetch) begin
            r_qpc[r_wp] <= r_pc;
            r_qin[r_wp] <= imem_data;
        end
    end
endmodule

// File: tb/tb_tinker_fetch_unit.sv
// tb_tinker_fetch_unit: directed table, corner sequences and randomized traffic against a queue model.
module tb_tinker_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_halted;
    logic        misalign_err;
    logic [2:0]  occupancy;

    logic [63:0] halt_addr = 64'h1;
    int          vecs = 0;
    int          errs = 0;

    logic [63:0] q_pc[$];
    logic [31:0] q_in[$];
    logic [63:0] m_pc;
    int          m_su, m_mode;
    logic        m_mis, m_halt;

    typedef struct {
        logic        rdy;
        logic        en;
        logic [63:0] addr;
        logic        vld;
        logic [63:0] pc;
        logic [2:0]  occ;
    } vec_t;
    vec_t tbl[10];

    always #5 clk = ~clk;

    function automatic logic [31:0] hashf(input logic [63:0] a);
        logic [31:0] w;
        w = a[31:0] * 32'h9E3779B1 ^ 32'h5A5A1234;
        if (w[31:27] == 5'h0f) w[27] = ~w[27];
        return w;
    endfunction

    function automatic logic [31:0] memf(input logic [63:0] a);
        return (a == halt_addr) ? {5'h0f, a[26:0]} : hashf(a);
    endfunction

    assign imem_data = (imem_addr == halt_addr) ? {5'h0f, imem_addr[26:0]} : hashf(imem_addr);

    tinker_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_en(imem_en),
        .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .fetch_halted(fetch_halted), .misalign_err(misalign_err), .occupancy(occupancy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_in.delete();
        m_pc   = 64'h2000;
        m_su   = 5;
        m_mode = 0;
        m_mis  = 1'b0;
        m_halt = 1'b0;
    endtask

    function automatic logic model_en();
        logic deq;
        deq = (q_pc.size() != 0) && id_ready;
        return (m_mode == 1) && !redirect_valid && (q_pc.size() < 4 || deq);
    endfunction

    task automatic compare_all();
        logic        vld;
        logic [63:0] hp;
        logic [31:0] hi;
        vld = q_pc.size() != 0;
        hp  = 64'h0;
        hi  = 32'h0;
        if (vld) begin
            hp = q_pc[0];
            hi = q_in[0];
        end
        chk("imem_addr", imem_addr, m_pc);
        chk("imem_en", {63'h0, imem_en}, {63'h0, model_en()});
        chk("if_valid", {63'h0, if_valid}, {63'h0, vld});
        chk("if_pc", if_pc, hp);
        chk("if_instr", {32'h0, if_instr}, {32'h0, hi});
        chk("fetch_halted", {63'h0, fetch_halted}, {63'h0, m_halt});
        chk("misalign_err", {63'h0, misalign_err}, {63'h0, m_mis});
        chk("occupancy", {61'h0, occupancy}, 64'(q_pc.size()));
    endtask

    task automatic model_step();
        logic        en, deq;
        logic [31:0] ins;
        deq = (q_pc.size() != 0) && id_ready;
        en  = model_en();
        if (m_mode == 0) begin
            if (m_su > 0) m_su--;
            if (m_su == 0) m_mode = 1;
        end else if (m_mode == 1 && redirect_valid) begin
            q_pc.delete();
            q_in.delete();
            if (redirect_pc[1:0] != 2'b00) begin
                m_mis  = 1'b1;
                m_halt = 1'b1;
                m_mode = 2;
            end else m_pc = redirect_pc;
        end else begin
            if (deq) begin
                void'(q_pc.pop_front());
                void'(q_in.pop_front());
            end
            if (en) begin
                ins = memf(m_pc);
                q_pc.push_back(m_pc);
                q_in.push_back(ins);
                m_pc = m_pc + 64'd4;
                if (ins[31:27] == 5'h0f) begin
                    m_mode = 2;
                    m_halt = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic rv, input logic [63:0] rp, input logic rd);
        redirect_valid = rv;
        redirect_pc    = rp;
        id_ready       = rd;
        #1;
        compare_all();
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        id_ready       = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 1'b0, 64'h2000, 1'b0, 64'h0, 3'd0};
        tbl[5] = '{1'b1, 1'b1, 64'h2000, 1'b0, 64'h0,    3'd0};
        tbl[6] = '{1'b1, 1'b1, 64'h2004, 1'b1, 64'h2000, 3'd1};
        tbl[7] = '{1'b1, 1'b1, 64'h2008, 1'b1, 64'h2004, 3'd1};
        tbl[8] = '{1'b1, 1'b1, 64'h200C, 1'b1, 64'h2008, 3'd1};
        tbl[9] = '{1'b1, 1'b1, 64'h2010, 1'b1, 64'h200C, 3'd1};

        do_reset();
        chk("reset_if_pc", if_pc, 64'h0);
        chk("reset_if_instr", {32'h0, if_instr}, 64'h0);
        chk("reset_imem_addr", imem_addr, 64'h2000);
        for (int i = 0; i < 10; i++) begin
            redirect_valid = 1'b0;
            id_ready       = tbl[i].rdy;
            #1;
            chk("tbl_imem_en", {63'h0, imem_en}, {63'h0, tbl[i].en});
            chk("tbl_imem_addr", imem_addr, tbl[i].addr);
            chk("tbl_if_valid", {63'h0, if_valid}, {63'h0, tbl[i].vld});
            chk("tbl_if_pc", if_pc, tbl[i].pc);
            chk("tbl_if_instr", {32'h0, if_instr}, {32'h0, tbl[i].vld ? hashf(tbl[i].pc) : 32'h0});
            chk("tbl_occupancy", {61'h0, occupancy}, {61'h0, tbl[i].occ});
            compare_all();
            model_step();
            @(negedge clk);
        end

        // backpressure: saturate, then drain back-to-back
        do_reset();
        repeat (13) step(1'b0, 64'h0, 1'b0);
        chk("bp_occupancy", {61'h0, occupancy}, 64'd4);
        chk("bp_imem_en", {63'h0, imem_en}, 64'd0);
        chk("bp_pc", imem_addr, 64'h2010);
        chk("bp_head_pc", if_pc, 64'h2000);
        chk("bp_head_instr", {32'h0, if_instr}, {32'h0, hashf(64'h2000)});
        repeat (10) step(1'b0, 64'h0, 1'b1);

        // redirect with three entries queued
        do_reset();
        repeat (8) step(1'b0, 64'h0, 1'b0);
        chk("rd_pre_occ", {61'h0, occupancy}, 64'd3);
        step(1'b1, 64'h3000, 1'b0);
        chk("rd_valid_after", {63'h0, if_valid}, 64'd0);
        chk("rd_occ_after", {61'h0, occupancy}, 64'd0);
        chk("rd_addr_after", imem_addr, 64'h3000);
        step(1'b0, 64'h0, 1'b1);
        chk("rd_first_valid", {63'h0, if_valid}, 64'd1);
        chk("rd_first_pc", if_pc, 64'h3000);
        chk("rd_first_instr", {32'h0, if_instr}, {32'h0, hashf(64'h3000)});
        repeat (4) step(1'b0, 64'h0, 1'b1);

        // halt instruction at 0x2008, later redirect ignored
        halt_addr = 64'h2008;
        do_reset();
        repeat (8) step(1'b0, 64'h0, 1'b1);
        chk("halt_flag", {63'h0, fetch_halted}, 64'd1);
        chk("halt_entry_pc", if_pc, 64'h2008);
        chk("halt_entry_op", {59'h0, if_instr[31:27]}, 64'h0f);
        step(1'b1, 64'h3000, 1'b1);
        repeat (4) step(1'b0, 64'h0, 1'b1);
        chk("halt_pc_stays", imem_addr, 64'h200C);
        chk("halt_drained", {63'h0, if_valid}, 64'd0);
        halt_addr = 64'h1;

        // misaligned redirect
        do_reset();
        repeat (7) step(1'b0, 64'h0, 1'b1);
        step(1'b1, 64'h3002, 1'b1);
        chk("mis_err", {63'h0, misalign_err}, 64'd1);
        chk("mis_halted", {63'h0, fetch_halted}, 64'd1);
        chk("mis_occ", {61'h0, occupancy}, 64'd0);
        repeat (3) step(1'b0, 64'h0, 1'b1);
        chk("mis_no_valid", {63'h0, if_valid}, 64'd0);

        // asynchronous reset with a full FIFO
        do_reset();
        repeat (10) step(1'b0, 64'h0, 1'b0);
        chk("ar_full", {61'h0, occupancy}, 64'd4);
        reset = 1'b1;
        #1;
        chk("ar_valid", {63'h0, if_valid}, 64'd0);
        chk("ar_occ", {61'h0, occupancy}, 64'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("ar_addr", imem_addr, 64'h2000);
        repeat (8) step(1'b0, 64'h0, 1'b1);

        // randomized traffic
        for (int r = 0; r < 6; r++) begin
            halt_addr = r[0] ? 64'h2000 + 64'(4 * $urandom_range(8, 200)) : 64'h1;
            do_reset();
            for (int c = 0; c < 300; c++) begin
                logic        rv;
                logic [63:0] rp;
                int          k;
                rv = ($urandom_range(0, 99) < 6);
                k  = $urandom_range(0, 99);
                rp = 64'h2000 + 64'(4 * $urandom_range(0, 255));
                if (k < 2) rp = rp + 64'($urandom_range(1, 3));
                else if (k < 5) rp = 64'hFFFF_FFFF_FFFF_FFF8;
                step(rv, rp, $urandom_range(0, 9) < 7);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
